multiport_regfile: RTL
======================

// Module: multiport_regfile
// PURPOSE
//  Parametrised GPR file for the NPC core with NR read / NW write ports.
//  Provides same-cycle write-to-read bypass, a hardwired x0, and a per-register
//  busy scoreboard (set on issue, cleared on writeback) for hazard checks.
//  Sits between decode (reads, issue), writeback (writes) and the difftest
//  debug read port.
// PARAMETERS
//  DATA_WIDTH  32  bits per register
//  REG_NUM     32  register count; power of two, >= 2
//  NR          2   read ports
//  NW          1   write ports
//  ZERO_REG    1   1: register 0 always reads 0, is never written, never busy
//  AW (localparam) = $clog2(REG_NUM)
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            async active-high reset
//  raddr      in   NR*AW        read addresses, port i at [i*AW +: AW]
//  rdata      out  NR*DATA_WIDTH read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  rbusy      out  NR           register at raddr[i] still awaiting a write
//  wen        in   NW           write enables
//  waddr      in   NW*AW        write addresses
//  wdata      in   NW*DATA_WIDTH write data
//  wclr       in   NW           write also clears busy bit of waddr[j]
//  iss_valid  in   1            instruction issued with destination iss_rd
//  iss_rd     in   AW           destination register to mark busy
//  dbg_addr   in   AW           debug/difftest read address
//  dbg_data   out  DATA_WIDTH   architectural value of dbg_addr (no bypass)
// BEHAVIOUR
//  - Reset (async, rst=1): all registers <= 0, all busy <= 0. While in reset,
//    rdata = 0 on every port, rbusy = 0, dbg_data = 0. Writes/issues ignored.
//  - Writes: on posedge clk, each port j with wen[j] writes wdata[j] to waddr[j].
//    Same address on several ports in one cycle: highest j wins.
//    waddr=0 with ZERO_REG=1: dropped (wen and wclr both ignored).
//  - Reads: combinational, 0-cycle latency. Priority: addr 0 & ZERO_REG -> 0;
//    else highest j with wen[j] & waddr[j]==raddr[i] -> wdata[j] (bypass);
//    else stored value.
//  - Scoreboard, posedge clk: busy[r] <= (busy[r] & ~clr_hit[r]) | set_hit[r],
//    where set_hit = iss_valid & iss_rd==r, clr_hit = any j with wen[j]&wclr[j]&waddr[j]==r.
//    Simultaneous set and clear of same r: set wins (newer producer), busy=1.
//    iss_rd=0 with ZERO_REG=1: no effect.
//  - rbusy[i] = busy[raddr[i]] & ~clr_hit[raddr[i]] (same-cycle clear is forwarded,
//    matching the data bypass); does not see the same-cycle issue (takes effect next cycle).
//  - wclr without wen has no effect. wen without wclr writes data, busy unchanged.
//  - dbg_data: stored value only, ignores in-flight writes; 0 for addr 0 if ZERO_REG.
//  - Reset asserted mid-operation: state clears immediately, pending writes lost.
// STRUCTURE
//  - Shared package/header: NPC_XLEN=32, NPC_REG_NUM=32, NPC_REG_AW=5 defines
//    reused by decode and writeback.
//  - One sub-module: regfile_scoreboard (busy vector, set/clear logic, rbusy lookup);
//    storage, write-priority and bypass muxes stay in the top.
// TESTING
//  1 Reset: write x5=0xDEAD, assert rst async mid-cycle -> rdata(x5)=0, rbusy=0 at once.
//  2 Bypass: wen=1 waddr=5 wdata=0x1234, raddr0=5 same cycle -> rdata0=0x1234;
//    next cycle wen=0 -> still 0x1234; dbg_data(5)=0 in write cycle, 0x1234 after.
//  3 x0: wen=1 waddr=0 wdata=0xFFFF_FFFF, iss_rd=0 -> rdata(0)=0, rbusy(0)=0 forever.
//  4 Port conflict (NW=2): both ports write x7, 0x11 (j=0) and 0x22 (j=1)
//    -> rdata(x7)=0x22 same cycle and after.
//  5 Scoreboard: issue rd=9 cycle N -> rbusy(9)=1 cycle N+1; cycle N+3 wen+wclr x9
//    -> rbusy=0 same cycle, busy=0 after; issue x9 + wclr x9 same cycle -> busy=1.
//  6 Random: 10k cycles vs reference model, NR=3 NW=2 DATA_WIDTH=64 REG_NUM=16,
//    ZERO_REG=0 run included (x0 writable, busy-able).

Source files
------------

// File: rtl/multiport_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multiport_regfile_pkg
//  Description : Shared NPC core constants (register width, register count,
//                register-address width). Decode, writeback and the register
//                file all take their defaults from here.
//  Revision    : 1.0  initial release
// ============================================================================
package multiport_regfile_pkg;

    localparam int NPC_XLEN    = 32;
    localparam int NPC_REG_NUM = 32;
    localparam int NPC_REG_AW  = 5;

endpackage : multiport_regfile_pkg
`default_nettype wire

// File: rtl/multiport_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : multiport_regfile_if
//  Description : Bus bundle between the core (decode / writeback / difftest)
//                and the register file.
//                  raddr/rdata/rbusy          : NR read ports
//                  wen/waddr/wdata/wclr       : NW write ports
//                  iss_valid/iss_rd           : issue-time busy marking
//                  dbg_addr/dbg_data          : architectural debug read
//                master = core side, slave = register file side.
//  Revision    : 1.0  initial release
// ============================================================================
interface multiport_regfile_if
    import multiport_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = NPC_XLEN,
    parameter int REG_NUM    = NPC_REG_NUM,
    parameter int NR         = 2,
    parameter int NW         = 1
);
    localparam int AW = $clog2(REG_NUM);

    logic [NR*AW-1:0]         raddr;
    logic [NR*DATA_WIDTH-1:0] rdata;
    logic [NR-1:0]            rbusy;
    logic [NW-1:0]            wen;
    logic [NW*AW-1:0]         waddr;
    logic [NW*DATA_WIDTH-1:0] wdata;
    logic [NW-1:0]            wclr;
    logic                     iss_valid;
    logic [AW-1:0]            iss_rd;
    logic [AW-1:0]            dbg_addr;
    logic [DATA_WIDTH-1:0]    dbg_data;

    modport master (
        output raddr, wen, waddr, wdata, wclr, iss_valid, iss_rd, dbg_addr,
        input  rdata, rbusy, dbg_data
    );

    modport slave (
        input  raddr, wen, waddr, wdata, wclr, iss_valid, iss_rd, dbg_addr,
        output rdata, rbusy, dbg_data
    );

endinterface : multiport_regfile_if
`default_nettype wire

// File: rtl/multiport_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : multiport_regfile_scoreboard
//  Description : Per-register busy tracking for the register file. A register
//                goes busy the cycle after it is issued as a destination and
//                is cleared by a write carrying wclr. Issue beats clear when
//                both hit the same register (the issue is the newer producer).
//                The read-side lookup forwards a same-cycle clear.
//  Ports       : clk, rst        clock, async active-high reset
//                i_raddr         NR packed read addresses
//                i_wen/i_waddr/i_wclr  write port controls
//                i_iss_valid/i_iss_rd  issue destination
//                o_rbusy         busy flag per read port
//  Revision    : 1.0  initial release
// ============================================================================
module multiport_regfile_scoreboard
    import multiport_regfile_pkg::*;
#(
    parameter int REG_NUM  = NPC_REG_NUM,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int ZERO_REG = 1
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic [NR*$clog2(REG_NUM)-1:0] i_raddr,
    input  wire logic [NW-1:0]                i_wen,
    input  wire logic [NW*$clog2(REG_NUM)-1:0] i_waddr,
    input  wire logic [NW-1:0]                i_wclr,
    input  wire logic                         i_iss_valid,
    input  wire logic [$clog2(REG_NUM)-1:0]   i_iss_rd,
    output logic      [NR-1:0]                o_rbusy
);
    localparam int AW = $clog2(REG_NUM);

    logic [REG_NUM-1:0] r_busy;
    logic [REG_NUM-1:0] w_set_hit;
    logic [REG_NUM-1:0] w_clr_hit;
    logic [AW-1:0]      w_rd_addr;

    // Register 0 is excluded from both masks when hardwired, so it can never
    // become busy.
    always_comb begin
        w_set_hit = '0;
        w_clr_hit = '0;
        if (i_iss_valid && !(ZERO_REG != 0 && i_iss_rd == '0)) begin
            w_set_hit[i_iss_rd] = 1'b1;
        end
        for (int j = 0; j < NW; j++) begin
            if (i_wen[j] && i_wclr[j] &&
                !(ZERO_REG != 0 && i_waddr[j*AW +: AW] == '0)) begin
                w_clr_hit[i_waddr[j*AW +: AW]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_hit) | w_set_hit;
        end
    end

    // Forward a same-cycle clear so hazard checks agree with the data bypass;
    // a same-cycle issue is deliberately not visible until the next cycle.
    always_comb begin
        o_rbusy   = '0;
        w_rd_addr = '0;
        for (int i = 0; i < NR; i++) begin
            w_rd_addr  = i_raddr[i*AW +: AW];
            o_rbusy[i] = r_busy[w_rd_addr] & ~w_clr_hit[w_rd_addr];
        end
    end

endmodule : multiport_regfile_scoreboard
`default_nettype wire

// File: rtl/multiport_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : multiport_regfile
//  Description : Parametrised NPC GPR file with NR combinational read ports,
//                NW write ports, same-cycle write-to-read bypass, optional
//                hardwired x0, a busy scoreboard and an architectural debug
//                read port (no bypass).
//  Ports       : clk   rising-edge clock
//                rst   async active-high reset; clears storage and busy bits
//                      and forces all read outputs to zero while held
//                bus   multiport_regfile_if.slave (read/write/issue/debug)
//  Revision    : 1.0  initial release
// ============================================================================
module multiport_regfile
    import multiport_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = NPC_XLEN,
    parameter int REG_NUM    = NPC_REG_NUM,
    parameter int NR         = 2,
    parameter int NW         = 1,
    parameter int ZERO_REG   = 1
) (
    input wire logic          clk,
    input wire logic          rst,
    multiport_regfile_if.slave bus
);
    localparam int AW = $clog2(REG_NUM);

    logic [DATA_WIDTH-1:0]    r_regs [REG_NUM];
    logic [NR*DATA_WIDTH-1:0] w_rdata;
    logic [AW-1:0]            w_rd_addr;
    logic [DATA_WIDTH-1:0]    w_rd_val;
    logic [DATA_WIDTH-1:0]    w_dbg_data;

    // Later ports are assigned last, so the highest-numbered port wins an
    // address conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < REG_NUM; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (bus.wen[j] && !(ZERO_REG != 0 && bus.waddr[j*AW +: AW] == '0)) begin
                    r_regs[bus.waddr[j*AW +: AW]] <= bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Read mux: stored value, overridden by the highest matching write port,
    // overridden by the hardwired zero, overridden by reset.
    always_comb begin
        w_rdata   = '0;
        w_rd_addr = '0;
        w_rd_val  = '0;
        for (int i = 0; i < NR; i++) begin
            w_rd_addr = bus.raddr[i*AW +: AW];
            w_rd_val  = r_regs[w_rd_addr];
            for (int j = 0; j < NW; j++) begin
                if (bus.wen[j] && bus.waddr[j*AW +: AW] == w_rd_addr) begin
                    w_rd_val = bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if ((ZERO_REG != 0 && w_rd_addr == '0) || rst) begin
                w_rd_val = '0;
            end
            w_rdata[i*DATA_WIDTH +: DATA_WIDTH] = w_rd_val;
        end
    end

    always_comb begin
        w_dbg_data = r_regs[bus.dbg_addr];
        if ((ZERO_REG != 0 && bus.dbg_addr == '0) || rst) begin
            w_dbg_data = '0;
        end
    end

    multiport_regfile_scoreboard #(
        .REG_NUM  (REG_NUM),
        .NR       (NR),
        .NW       (NW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_raddr     (bus.raddr),
        .i_wen       (bus.wen),
        .i_waddr     (bus.waddr),
        .i_wclr      (bus.wclr),
        .i_iss_valid (bus.iss_valid),
        .i_iss_rd    (bus.iss_rd),
        .o_rbusy     (bus.rbusy)
    );

    assign bus.rdata    = w_rdata;
    assign bus.dbg_data = w_dbg_data;

endmodule : multiport_regfile
`default_nettype wire
